e_mdu: RTL

//  Execute-stage multiply/divide unit. Consumes E_instr-decoded op, E_rs, E_rt from the ID/EX pipeline register.

---
 rtl/e_mdu_pkg.sv | 54 +++++
 rtl/e_mdu.sv | 122 ++++++++++++
 2 files changed

// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: op encodings (also used by the D-stage decoder),
// a result pair type and the divide helper used by the execute-stage MDU.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_res_t;

  // True for the ops that launch a multi-cycle operation.
  function automatic logic mdu_is_start(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Quotient truncated toward zero in lo, remainder with the sign of the
  // dividend in hi. Works on magnitudes so the most-negative / -1 case wraps
  // to 0x80000000 cleanly. A zero divisor is replaced by one to keep the
  // datapath defined; the caller discards that result.
  function automatic mdu_res_t mdu_divide(input logic [31:0] n,
                                          input logic [31:0] d,
                                          input logic        is_signed);
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag_n;
    logic [31:0] mag_d;
    logic [31:0] q;
    logic [31:0] r;
    mdu_res_t    res;
    neg_r = is_signed & n[31];
    neg_q = is_signed & (n[31] ^ d[31]);
    mag_n = neg_r ? -n : n;
    mag_d = (is_signed & d[31]) ? -d : d;
    if (mag_d == 32'd0) mag_d = 32'd1;
    q      = mag_n / mag_d;
    r      = mag_n % mag_d;
    res.lo = neg_q ? -q : q;
    res.hi = neg_r ? -r : r;
    return res;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit. Owns architectural HI/LO, launches
// mult/div with a fixed-latency countdown and exposes busy for the hazard unit.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_valid,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  output logic        E_mdu_start,
  output logic        E_mdu_busy,
  output logic [31:0] E_mdu_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             div_zero_q, div_zero_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0]      smul;
  logic [63:0]      umul;
  mdu_res_t         sdiv;
  mdu_res_t         udiv;

  assign smul = $signed({{32{E_rs[31]}}, E_rs}) * $signed({{32{E_rt[31]}}, E_rt});
  assign umul = {32'd0, E_rs} * {32'd0, E_rt};
  assign sdiv = mdu_divide(E_rs, E_rt, 1'b1);
  assign udiv = mdu_divide(E_rs, E_rt, 1'b0);

  assign E_mdu_busy  = (cnt_q != '0);
  assign E_mdu_start = E_valid & mdu_is_start(E_mdu_op) & ~E_mdu_busy;
  assign HI          = hi_q;
  assign LO          = lo_q;

  // Read port for mfhi/mflo; bubbles and all other ops read as zero.
  always_comb begin
    E_mdu_out = 32'd0;
    if (E_valid && (E_mdu_op == MDU_MFHI)) E_mdu_out = hi_q;
    if (E_valid && (E_mdu_op == MDU_MFLO)) E_mdu_out = lo_q;
  end

  // Next-state: count down an in-flight op and commit on its last cycle,
  // otherwise accept a new start or an mthi/mtlo write.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned and infers a latch.
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    if (E_mdu_busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if ((cnt_q == CNT_W'(1)) && !div_zero_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (E_valid) begin
      case (E_mdu_op)
        MDU_MULT: begin
          {pend_hi_d, pend_lo_d} = smul;
          div_zero_d             = 1'b0;
          cnt_d                  = CNT_W'(MULT_CYCLES);
        end
        MDU_MULTU: begin
          {pend_hi_d, pend_lo_d} = umul;
          div_zero_d             = 1'b0;
          cnt_d                  = CNT_W'(MULT_CYCLES);
        end
        MDU_DIV: begin
          pend_hi_d  = sdiv.hi;
          pend_lo_d  = sdiv.lo;
          div_zero_d = (E_rt == 32'd0);
          cnt_d      = CNT_W'(DIV_CYCLES);
        end
        MDU_DIVU: begin
          pend_hi_d  = udiv.hi;
          pend_lo_d  = udiv.lo;
          div_zero_d = (E_rt == 32'd0);
          cnt_d      = CNT_W'(DIV_CYCLES);
        end
        MDU_MTHI: hi_d = E_rs;
        MDU_MTLO: lo_d = E_rs;
        default:  ;
      endcase
    end
  end

  // State registers; reset aborts any in-flight op and clears HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: pending result regs are reset too, so nothing stale can ever commit after reset.
      cnt_q      <= '0;
      pend_hi_q  <= 32'd0;
      pend_lo_q  <= 32'd0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule
